// File: rtl/mul_mod_sequencer.sv
//------------------------------------------------------------------------------
// mul_mod_sequencer: multi-cycle MUL (shift-add) / MOD (restoring division)
// controller for the Execute stage. Optional macro: MULSEQ_EARLY_EXIT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mul_mod_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic [2:0]       aluControlE,
  input  logic             flushE,
  input  logic [WIDTH-1:0] srcAE,
  input  logic [WIDTH-1:0] srcBE,
  output logic             stallE,
  output logic             busy,
  output logic             resultValid,
  output logic [WIDTH-1:0] result
);

  localparam logic [2:0] ALU_MUL = 3'b110;
  localparam logic [2:0] ALU_MOD = 3'b100;
  localparam int         CNT_W   = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_MOD, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;     // MUL accumulator / MOD remainder
  logic [WIDTH-1:0]   opa_q, opa_d;     // multiplicand / dividend
  logic [WIDTH-1:0]   opb_q, opb_d;     // multiplier / divisor
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               is_mul, is_mod, accept, cnt_last, mul_last;
  logic [WIDTH-1:0]   mul_acc, mplier_nx, rem_nx;
  logic [WIDTH:0]     rem_sh;

  assign is_mul    = (aluControlE == ALU_MUL);
  assign is_mod    = (aluControlE == ALU_MOD);
  assign accept    = (state_q == S_IDLE) && startE && !flushE && (is_mul || is_mod);
  assign cnt_last  = (cnt_q == CNT_W'(1));
  assign mul_acc   = opb_q[0] ? (acc_q + opa_q) : acc_q;
  assign mplier_nx = opb_q >> 1;

  // Shifted remainder keeps one extra bit so divisors above 2^(WIDTH-1) work.
  assign rem_sh = {acc_q, opa_q[WIDTH-1]};
  assign rem_nx = (rem_sh >= {1'b0, opb_q}) ? (rem_sh[WIDTH-1:0] - opb_q)
                                             : rem_sh[WIDTH-1:0];

`ifdef MULSEQ_EARLY_EXIT_EN
  assign mul_last = cnt_last || (mplier_nx == '0);
`else
  assign mul_last = cnt_last;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    stallE      = 1'b0;
    busy        = 1'b0;
    resultValid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          stallE = 1'b1;
          acc_d  = '0;
          opa_d  = srcAE;
          opb_d  = srcBE;
          cnt_d  = CNT_W'(WIDTH);
          if (is_mod) begin
            if (srcBE == '0) begin
              result_d = srcAE;
              cnt_d    = '0;
              state_d  = S_DONE;
            end else begin
              state_d  = S_MOD;
            end
          end else begin
`ifdef MULSEQ_EARLY_EXIT_EN
            if (srcBE == '0) begin
              result_d = '0;
              cnt_d    = '0;
              state_d  = S_DONE;
            end else begin
              state_d  = S_MUL;
            end
`else
            state_d = S_MUL;
`endif
          end
        end
      end
      S_MUL: begin
        stallE = 1'b1;
        busy   = 1'b1;
        acc_d  = mul_acc;
        opa_d  = opa_q << 1;
        opb_d  = mplier_nx;
        cnt_d  = cnt_q - CNT_W'(1);
        if (mul_last) begin
          result_d = mul_acc;
          state_d  = S_DONE;
        end
      end
      S_MOD: begin
        stallE = 1'b1;
        busy   = 1'b1;
        acc_d  = rem_nx;
        opa_d  = opa_q << 1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_last) begin
          result_d = rem_nx;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        resultValid = !flushE;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A flush abandons the instruction before its result is committed.
    if (flushE && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = result_q;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

`default_nettype wire
